spi_mosi_tx: RTL and testbench

SPI_MOSI_TX -- requirements
Module: spi_mosi_tx

---
 rtl/spi_mosi_tx_if.sv | 24 ++
 rtl/spi_mosi_tx.sv | 120 ++++++++++++
 tb/tb_spi_mosi_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_mosi_tx_if.sv
// rtl/spi_mosi_tx_if.sv - word handshake and serial output bundle for spi_mosi_tx
interface spi_mosi_tx_if #(
  parameter int DSIZE = 8
);
  logic             spi_cs;
  logic             data_av;
  logic             read_req;
  logic [DSIZE-1:0] spi_mosi_in;
  logic             spi_mosi_out;
  logic             data_ack;
  logic             busy;
  logic             word_done;
  logic             aborted;

  modport master (
    output spi_cs, data_av, read_req, spi_mosi_in,
    input  spi_mosi_out, data_ack, busy, word_done, aborted
  );

  modport slave (
    input  spi_cs, data_av, read_req, spi_mosi_in,
    output spi_mosi_out, data_ack, busy, word_done, aborted
  );
endinterface

// File: rtl/spi_mosi_tx.sv
// rtl/spi_mosi_tx.sv - parallel-to-serial MOSI shifter with back-to-back words and cs abort
module spi_mosi_tx #(
  parameter int DSIZE      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic spi_clk,
  input logic spi_rst_n,
  spi_mosi_tx_if.slave bus
);
  localparam int CW = $clog2(DSIZE);
  localparam logic [CW-1:0] LAST = CW'(DSIZE - 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [DSIZE-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, idx;
  logic             out_q, out_nxt;
  logic             ack_q, ack_nxt;
  logic             done_q, done_nxt;
  logic             abrt_q, abrt_nxt;
  logic             cap, last_bit;

  assign cap      = bus.data_av & ~bus.read_req;
  assign last_bit = (cnt == LAST);
  // cnt is the position within the word; idx maps it to a bit of the held word
  assign idx      = MSB_FIRST ? (LAST - cnt) : cnt;

  always_ff @(posedge spi_clk or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      out_q  <= IDLE_LEVEL;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      abrt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
      ack_q  <= ack_nxt;
      done_q <= done_nxt;
      abrt_q <= abrt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.spi_cs && cap) state_nxt = ARM;
      ARM:     if (!bus.spi_cs) state_nxt = SHIFT;
      SHIFT: begin
        if (bus.spi_cs)    state_nxt = IDLE;
        else if (last_bit) state_nxt = cap ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    ack_nxt   = 1'b0;
    done_nxt  = 1'b0;
    abrt_nxt  = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = IDLE_LEVEL;
        cnt_nxt = '0;
        if (bus.spi_cs && cap) begin
          shreg_nxt = bus.spi_mosi_in;
          ack_nxt   = 1'b1;
        end
      end
      ARM: begin
        if (bus.spi_cs) begin
          out_nxt = IDLE_LEVEL;
        end else begin
          out_nxt = shreg[idx];
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (bus.spi_cs) begin
          abrt_nxt  = 1'b1;
          out_nxt   = IDLE_LEVEL;
          cnt_nxt   = '0;
          shreg_nxt = '0;
        end else begin
          out_nxt = shreg[idx];
          if (last_bit) begin
            // reload here so the next word's first bit follows with no gap
            done_nxt = 1'b1;
            cnt_nxt  = '0;
            if (cap) begin
              shreg_nxt = bus.spi_mosi_in;
              ack_nxt   = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        out_nxt = IDLE_LEVEL;
        cnt_nxt = '0;
      end
    endcase
  end

  assign bus.spi_mosi_out = out_q;
  assign bus.data_ack     = ack_q;
  assign bus.word_done    = done_q;
  assign bus.aborted      = abrt_q;
  assign bus.busy         = (state == ARM) || (state == SHIFT);
endmodule

// File: tb/tb_spi_mosi_tx.sv
// tb/tb_spi_mosi_tx.sv - bench driving an LSB-first/idle-0 and an MSB-first/idle-1 instance in lockstep
module tb_spi_mosi_tx;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  bit   cur_av;
  logic [7:0] wq[$];

  spi_mosi_tx_if #(.DSIZE(8)) if0 ();
  spi_mosi_tx_if #(.DSIZE(8)) if1 ();

  spi_mosi_tx #(.DSIZE(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (
    .spi_clk(clk), .spi_rst_n(rst_n), .bus(if0)
  );
  spi_mosi_tx #(.DSIZE(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (
    .spi_clk(clk), .spi_rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit cs, input bit av, input bit rr, input logic [7:0] d);
    if0.spi_cs = cs; if0.data_av = av; if0.read_req = rr; if0.spi_mosi_in = d;
    if1.spi_cs = cs; if1.data_av = av; if1.read_req = rr; if1.spi_mosi_in = d;
    cur_av = av;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // k: word position whose bit should be on the line (-1 = idle level)
  task automatic expect_cyc(input string tag, input int k, input logic [7:0] w,
                            input bit ack, input bit done, input bit abrt, input bit bsy);
    logic [2:0] p;
    logic e0, e1;
    p  = 3'(k);
    e0 = (k < 0) ? 1'b0 : w[p];
    e1 = (k < 0) ? 1'b1 : w[3'd7 - p];
    chk({tag, "/out_lsb"},  if0.spi_mosi_out, e0);
    chk({tag, "/out_msb"},  if1.spi_mosi_out, e1);
    chk({tag, "/ack_lsb"},  if0.data_ack,  ack);
    chk({tag, "/ack_msb"},  if1.data_ack,  ack);
    chk({tag, "/done_lsb"}, if0.word_done, done);
    chk({tag, "/done_msb"}, if1.word_done, done);
    chk({tag, "/abrt_lsb"}, if0.aborted,   abrt);
    chk({tag, "/abrt_msb"}, if1.aborted,   abrt);
    chk({tag, "/busy_lsb"}, if0.busy,      bsy);
    chk({tag, "/busy_msb"}, if1.busy,      bsy);
  endtask

  // Sends every word in wq back to back: capture with cs high, hold, then cs low
  task automatic stream(input string tag, input int hold);
    int last;
    last = wq.size() - 1;
    drive(1'b1, 1'b1, 1'b0, wq[0]);
    tick();
    expect_cyc({tag, "/cap"}, -1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, last >= 1, 1'b0, (last >= 1) ? wq[1] : 8'($urandom));
    for (int h = 0; h < hold; h++) begin
      tick();
      expect_cyc({tag, "/arm"}, -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, cur_av, 1'b0, if0.spi_mosi_in);
    for (int j = 0; j <= last; j++) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        expect_cyc({tag, "/bit"}, k, wq[j], (k == 7) && (j < last), k == 7, 1'b0,
                   !((k == 7) && (j == last)));
        if ((k == 7) && (j < last))
          drive(1'b0, j + 2 <= last, 1'b0, (j + 2 <= last) ? wq[j + 2] : 8'($urandom));
        else if (!cur_av)
          drive(1'b0, 1'b0, 1'b0, 8'($urandom));
      end
    end
    tick();
    expect_cyc({tag, "/idle"}, -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'($urandom));
  endtask

  // Raises cs after n bits with a new word offered on the abort edge, then sends that word
  task automatic abort_at(input string tag, input logic [7:0] w, input int n, input logic [7:0] nw);
    drive(1'b1, 1'b1, 1'b0, w);
    tick();
    expect_cyc({tag, "/cap"}, -1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int k = 0; k < n; k++) begin
      tick();
      expect_cyc({tag, "/bit"}, k, w, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b0, nw);
    tick();
    expect_cyc({tag, "/abort"}, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    wq = '{nw};
    stream({tag, "/next"}, 0);
  endtask

  initial begin
    logic [7:0] w;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    expect_cyc("reset", -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_cyc("post_reset", -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    wq = '{8'hA5};
    stream("a5", 1);
    wq = '{8'h01, 8'h80};
    stream("b2b", 0);
    abort_at("abort3", 8'h3C, 3, 8'hC3);

    drive(1'b1, 1'b1, 1'b1, 8'h5A);
    repeat (3) begin
      tick();
      expect_cyc("read_req", -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    wq = '{8'h5A};
    stream("rr_drop", 0);

    repeat (8) begin
      wq.delete();
      repeat ($urandom_range(1, 3)) wq.push_back(8'($urandom));
      stream("rnd", int'($urandom_range(0, 2)));
    end
    repeat (4) abort_at("rnd_abort", 8'($urandom), int'($urandom_range(1, 7)), 8'($urandom));

    w = 8'($urandom);
    drive(1'b1, 1'b1, 1'b0, w);
    tick();
    expect_cyc("rst_mid/cap", -1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_cyc("rst_mid/bit", k, w, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 expect_cyc("rst_mid/async", -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      tick();
      expect_cyc("rst_mid/held", -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      expect_cyc("rst_mid/release", -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    wq = '{8'($urandom)};
    stream("rst_mid/after", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
